// File: rtl/maxpool_sched_pkg.sv
// Shared definitions for the max-pool sequencing controller.
package maxpool_sched_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_FIN
    } state_t;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/maxpool_sched_pooling.sv
// Four-input fp16 maximum; ties resolve to the earlier operand.
module pooling #(
    parameter int WIDTH = maxpool_sched_pkg::DATA_WIDTH
) (
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] w3,
    output logic [WIDTH-1:0] y
);

    // Map sign-magnitude onto an unsigned key with the same ordering.
    function automatic logic [WIDTH-1:0] key(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ~v : {1'b1, v[WIDTH-2:0]};
    endfunction

    logic [WIDTH-1:0] m01;
    logic [WIDTH-1:0] m23;

    assign m01 = (key(w1) > key(w0)) ? w1 : w0;
    assign m23 = (key(w3) > key(w2)) ? w3 : w2;
    assign y   = (key(m23) > key(m01)) ? m23 : m01;

endmodule

// File: rtl/maxpool_sched.sv
// Address-driven 2x2/stride-2 max-pool sequencer: four reads per window,
// one pooled write, channel -> row -> column order.
module maxpool_sched #(
    parameter int DATA_WIDTH = maxpool_sched_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 24,
    parameter int MAX_SIZE   = 256,
    parameter int MAX_CH     = 64
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [maxpool_sched_pkg::clog2(MAX_SIZE):0] cfg_size,
    input  logic [maxpool_sched_pkg::clog2(MAX_CH):0]   cfg_channels,
    input  logic [ADDR_WIDTH-1:0]                       cfg_in_base,
    input  logic [ADDR_WIDTH-1:0]                       cfg_out_base,
    output logic                                        rd_en,
    output logic [ADDR_WIDTH-1:0]                       rd_addr,
    input  logic [DATA_WIDTH-1:0]                       rd_data,
    output logic                                        wr_en,
    output logic [ADDR_WIDTH-1:0]                       wr_addr,
    output logic [DATA_WIDTH-1:0]                       wr_data,
    input  logic                                        wr_ready,
    output logic                                        busy,
    output logic                                        done
);
    import maxpool_sched_pkg::*;

    localparam int SW = clog2(MAX_SIZE) + 1;
    localparam int CW = clog2(MAX_CH) + 1;
    localparam int OW = SW - 1;

    state_t                 state, nxt;
    logic [1:0]             k;
    logic [SW-1:0]          size_q;
    logic [CW-1:0]          chn_q, ch_q;
    logic [OW-1:0]          c_q, r_q;
    logic [ADDR_WIDTH-1:0]  in_ptr, out_ptr;
    logic                   trivial_q;
    logic [DATA_WIDTH-1:0]  win [4];
    logic [DATA_WIDTH-1:0]  pooled;

    logic [SW-1:0]          size_eff;
    logic                   trivial;
    logic [OW-1:0]          half;
    logic [ADDR_WIDTH-1:0]  s_ext;
    logic                   last_c, last_r, last_ch;

    assign size_eff = cfg_size & ~SW'(1);
    assign trivial  = (size_eff == '0) || (cfg_channels == '0);
    assign half     = size_q[SW-1:1];
    assign s_ext    = ADDR_WIDTH'(size_q);
    assign last_c   = (c_q == half - OW'(1));
    assign last_r   = (r_q == half - OW'(1));
    assign last_ch  = (ch_q == chn_q - CW'(1));

    pooling #(.WIDTH(DATA_WIDTH)) u_pool (
        .w0 (win[0]),
        .w1 (win[1]),
        .w2 (win[2]),
        .w3 (win[3]),
        .y  (pooled)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt   = state;
        rd_en = 1'b0;
        wr_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            // A degenerate config parks one cycle in S_CAP so busy still shows.
            S_IDLE: if (start) nxt = trivial ? S_CAP : S_RD;
            S_RD: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (k == 2'd3) nxt = S_CAP;
            end
            S_CAP: begin
                busy = 1'b1;
                nxt  = trivial_q ? S_FIN : S_WR;
            end
            S_WR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) nxt = (last_c && last_r && last_ch) ? S_FIN : S_RD;
            end
            S_FIN: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // in_ptr tracks the top-left element of the current window.
    assign rd_addr = rd_en ? (in_ptr + (k[1] ? s_ext : '0) + ADDR_WIDTH'(k[0])) : '0;
    assign wr_addr = wr_en ? out_ptr : '0;
    assign wr_data = wr_en ? pooled : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= '0;
            size_q    <= '0;
            chn_q     <= '0;
            ch_q      <= '0;
            c_q       <= '0;
            r_q       <= '0;
            in_ptr    <= '0;
            out_ptr   <= '0;
            trivial_q <= 1'b0;
            for (int i = 0; i < 4; i++) win[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    size_q    <= size_eff;
                    chn_q     <= cfg_channels;
                    in_ptr    <= cfg_in_base;
                    out_ptr   <= cfg_out_base;
                    trivial_q <= trivial;
                    k         <= '0;
                    ch_q      <= '0;
                    r_q       <= '0;
                    c_q       <= '0;
                end
                S_RD: begin
                    k <= k + 2'd1;
                    if (k != 2'd0) win[k - 2'd1] <= rd_data;
                end
                S_CAP: if (!trivial_q) win[3] <= rd_data;
                S_WR: if (wr_ready) begin
                    out_ptr <= out_ptr + ADDR_WIDTH'(1);
                    k       <= '0;
                    if (last_c) begin
                        // Skip the odd row already covered by this window pair.
                        c_q    <= '0;
                        in_ptr <= in_ptr + ADDR_WIDTH'(2) + s_ext;
                        if (last_r) begin
                            r_q  <= '0;
                            ch_q <= ch_q + CW'(1);
                        end else begin
                            r_q <= r_q + OW'(1);
                        end
                    end else begin
                        c_q    <= c_q + OW'(1);
                        in_ptr <= in_ptr + ADDR_WIDTH'(2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_sched.sv
// Scoreboard bench for maxpool_sched: a real-valued window-max model feeds an
// expected-write queue that a free-running monitor drains.
module tb_maxpool_sched;

    logic        clk, reset, start;
    logic [8:0]  cfg_size;
    logic [6:0]  cfg_channels;
    logic [23:0] cfg_in_base, cfg_out_base;
    logic        rd_en, wr_en, wr_ready, busy, done;
    logic [23:0] rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;

    maxpool_sched dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_size(cfg_size), .cfg_channels(cfg_channels),
        .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    logic [15:0] mem [logic [23:0]];
    always @(posedge clk) if (rd_en) rd_data <= mem.exists(rd_addr) ? mem[rd_addr] : 16'h0;

    typedef struct { logic [23:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_q[$];

    int n_checks = 0, n_fail = 0;
    int wr_cnt, n_rd, bad_rd, n_stall, stall_idx, stall_left, stab_cycles, stab_bad;
    bit rstall, stab_seen;
    logic [23:0] h_addr, cur_in_base, rd_log[$];
    logic [15:0] h_data;
    int cur_span, last_lat, last_busy;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] int_to_fp16(input int n);
        int e;
        if (n == 0) return 16'h0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 5'(e + 15), 10'((n << 10) >> e)};
    endfunction

    function automatic real f2r(input logic [15:0] h);
        real m;
        int e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(h[9:0]) * 2.0 ** (-24);
        else        m = real'(1024 + int'(h[9:0])) * 2.0 ** (e - 25);
        return h[15] ? -m : m;
    endfunction

    // Monitor and wr_ready driver share one process so the ready decision
    // and the acceptance check see the same cycle.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (wr_en && wr_cnt == stall_idx && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
            end else if (rstall && wr_en && $urandom_range(3) == 0) wr_ready = 1'b0;
            else wr_ready = 1'b1;
            if (rd_en) begin
                if (rd_log.size() < 4) rd_log.push_back(rd_addr);
                n_rd++;
                if (int'(24'(rd_addr - cur_in_base)) >= cur_span) bad_rd++;
            end
            if (wr_en) begin
                if (!wr_ready) n_stall++;
                if (wr_cnt == stall_idx) begin
                    if (!stab_seen) begin
                        stab_seen = 1;
                        h_addr = wr_addr;
                        h_data = wr_data;
                    end else if (wr_addr != h_addr || wr_data != h_data) stab_bad++;
                    stab_cycles++;
                end
                if (wr_ready) begin
                    if (exp_q.size() == 0) chk("unexpected write", wr_addr, 0);
                    else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", wr_addr, e.addr);
                        chk("wr_data", wr_data, e.data);
                    end
                    wr_cnt++;
                end
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, " rd_en"}, rd_en, 0);
        chk({nm, " wr_en"}, wr_en, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " rd_addr"}, rd_addr, 0);
        chk({nm, " wr_addr"}, wr_addr, 0);
        chk({nm, " wr_data"}, wr_data, 0);
    endtask

    // mode: 0 = RAM holds element index, 1 = same with odd channels negated, 2 = random fp16
    task automatic run(input string nm, input int size, input int chans,
                       input logic [23:0] inb, input logic [23:0] outb, input int mode,
                       input int sidx, input int slen, input bit rs, input bit midstart,
                       input int abort_at);
        int s, o, lat, bcyc, outs;
        bit triv;
        s = size & ~1;
        o = s / 2;
        triv = (s < 2) || (chans == 0);
        outs = triv ? 0 : chans * o * o;
        mem.delete();
        exp_q.delete();
        for (int ch = 0; ch < chans; ch++)
            for (int i = 0; i < s * s; i++) begin
                logic [15:0] v;
                if (mode == 2) begin
                    do v = 16'($urandom); while (v[14:10] == 5'h1f);
                    if (v == 16'h8000) v = 16'h0;
                end else begin
                    v = int_to_fp16(i);
                    if (mode == 1 && ch % 2 == 1) v = v | 16'h8000;
                end
                mem[24'(inb + 24'(ch * s * s + i))] = v;
            end
        if (!triv)
            for (int ch = 0; ch < chans; ch++)
                for (int r = 0; r < o; r++)
                    for (int c = 0; c < o; c++) begin
                        wr_t e;
                        logic [15:0] best, v;
                        best = 16'h0;
                        for (int q = 0; q < 4; q++) begin
                            v = mem[24'(inb + 24'(ch * s * s + (2 * r + q / 2) * s + 2 * c + q % 2))];
                            if (q == 0 || f2r(v) > f2r(best)) best = v;
                        end
                        e.addr = 24'(outb + 24'(ch * o * o + r * o + c));
                        e.data = best;
                        exp_q.push_back(e);
                    end
        wr_cnt = 0; n_rd = 0; bad_rd = 0; n_stall = 0;
        stall_idx = sidx; stall_left = slen; stab_cycles = 0; stab_bad = 0; stab_seen = 0;
        rstall = rs;
        rd_log.delete();
        cur_in_base = inb;
        cur_span = chans * s * s;
        cfg_size = 9'(size);
        cfg_channels = 7'(chans);
        cfg_in_base = inb;
        cfg_out_base = outb;
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        bcyc = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (lat == 3) begin
                cfg_size = 9'($urandom);
                cfg_channels = 7'($urandom);
                cfg_in_base = 24'($urandom);
                cfg_out_base = 24'($urandom);
            end
            if (midstart && lat == 10) start = 1'b1;
            if (midstart && lat == 11) start = 1'b0;
            if (abort_at > 0 && lat == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk_zero({nm, " after reset"});
                reset = 1'b0;
                exp_q.delete();
                @(negedge clk);
                chk({nm, " idle rd_en"}, rd_en, 0);
                chk({nm, " idle busy"}, busy, 0);
                return;
            end
            if (busy) bcyc++;
            if (done) break;
            if (lat > 20000) begin
                chk({nm, " timeout"}, lat, 0);
                break;
            end
        end
        last_lat = lat;
        last_busy = bcyc;
        chk({nm, " latency"}, lat, triv ? 2 : 6 * outs + 1 + n_stall);
        chk({nm, " busy cycles"}, bcyc, triv ? 1 : lat - 1);
        chk({nm, " writes"}, wr_cnt, outs);
        chk({nm, " reads"}, n_rd, 4 * outs);
        chk({nm, " pending"}, exp_q.size(), 0);
        chk({nm, " read range"}, bad_rd, 0);
        @(negedge clk);
        chk({nm, " done pulse"}, done, 0);
    endtask

    task automatic chk_first_window(input string nm);
        chk({nm, " rd_log size"}, rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            chk({nm, " rd0"}, rd_log[0], 0);
            chk({nm, " rd1"}, rd_log[1], 1);
            chk({nm, " rd2"}, rd_log[2], 4);
            chk({nm, " rd3"}, rd_log[3], 5);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        cfg_size = 0; cfg_channels = 0; cfg_in_base = 0; cfg_out_base = 0;
        stall_idx = -1; stall_left = 0; rstall = 0; cur_span = 0; cur_in_base = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        run("s4c1", 4, 1, 24'h0, 24'h100, 0, -1, 0, 0, 0, 0);
        chk("s4c1 done at 25", last_lat, 25);
        chk_first_window("s4c1");

        run("s4c2neg", 4, 2, 24'h0, 24'h100, 1, -1, 0, 0, 0, 0);
        chk("s4c2neg done at 49", last_lat, 49);

        run("stall", 4, 1, 24'h0, 24'h100, 0, 1, 3, 0, 0, 0);
        chk("stall done at 28", last_lat, 28);
        chk("stall stable cycles", stab_cycles, 4);
        chk("stall hold changes", stab_bad, 0);
        chk("stall held addr", h_addr, 24'h101);

        run("odd5", 5, 1, 24'h0, 24'h100, 0, -1, 0, 0, 0, 0);
        chk("odd5 done at 25", last_lat, 25);

        run("ch0", 4, 0, 24'h0, 24'h100, 0, -1, 0, 0, 0, 0);
        run("size1", 1, 3, 24'h0, 24'h100, 0, -1, 0, 0, 0, 0);

        run("abort", 4, 1, 24'h0, 24'h100, 0, -1, 0, 0, 0, 8);
        run("rerun", 4, 1, 24'h0, 24'h100, 0, -1, 0, 0, 1, 0);
        chk("rerun done at 25", last_lat, 25);
        chk("rerun busy", last_busy, 24);
        chk_first_window("rerun");

        run("wrap", 4, 2, 24'hFFFFF0, 24'hFFFFFC, 2, -1, 0, 1, 0, 0);
        for (int t = 0; t < 6; t++)
            run("rand", int'($urandom_range(9, 2)), int'($urandom_range(3, 1)),
                24'($urandom), 24'($urandom), 2, -1, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
